lc2k_alu_seq: RTL and testbench
===============================

LC2K_ALU_SEQ -- requirements
Module: lc2k_alu_seq

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, operand/result width in bits (legal: 8..64, power of two).
REQ-002 SHALL have parameter SHAMT_LEN, default $clog2(DATA_LEN), shift-amount width taken from b[SHAMT_LEN-1:0].
REQ-003 SHALL have port clock  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port op  input  3  operation code.
REQ-008 SHALL have ports a, b  input  DATA_LEN  operands.
REQ-009 SHALL have port out_valid  output  1  result held.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out  output  DATA_LEN  result.
REQ-012 SHALL have port eq  output  1  result == 0.
REQ-013 SHALL have port err  output  1  illegal op flagged with this result.

Function
REQ-014 SHALL transfer a request when in_valid && in_ready, and a result when out_valid && out_ready.
REQ-015 SHALL decode op: 000 ADD a+b; 001 NOR ~(a|b); 010 SUB a-b; 011 AND a&b; 100 SLL a<<shamt; 101 SRL a>>shamt (logical); 110 MUL; 111 reserved.
REQ-016 SHALL truncate all results to DATA_LEN bits (wrap-around, no carry/overflow output).
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-018 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-019 SHALL, on accept of a single-cycle op (000-101), register out/eq/err and enter DONE; out_valid rises the next cycle (latency 1).
REQ-020 SHALL, on accept of MUL with ALU_MUL_EN defined, enter BUSY and compute the low DATA_LEN bits of a*b by iterative shift-add, one bit per cycle, entering DONE after exactly DATA_LEN cycles in BUSY (latency DATA_LEN+1).
REQ-021 SHALL hold in_ready low, ignore in_valid, and keep operands internally latched for the whole of BUSY.
REQ-022 SHALL, in DONE, hold out/eq/err stable while out_ready is low.
REQ-023 SHALL, in DONE with out_ready high and a new accept in the same cycle, load the new request (back-to-back throughput 1 per cycle for single-cycle ops).
REQ-024 SHALL, in DONE with out_ready high and no accept, return to IDLE.
REQ-025 SHALL, for op 111 (or 110 without ALU_MUL_EN), produce out = 0, eq = 1, err = 1, latency 1.
REQ-026 SHALL compute eq from the final registered result, never from intermediate BUSY values.
REQ-027 SHALL drive out_valid = (state==DONE).

Reset
REQ-028 SHALL, on reset asserted (any time, including mid-BUSY), immediately enter IDLE and force out = 0, eq = 0, err = 0, out_valid = 0, discarding any in-flight request.
REQ-029 SHALL drive in_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL compile the iterative multiplier and BUSY state only when macro LC2K_ALU_MUL_EN is defined.
REQ-031 SHALL, without LC2K_ALU_MUL_EN, treat op 110 as illegal per REQ-025, with state BUSY unreachable and no multiplier logic.

Verification
REQ-032 ADD a=32'h7FFFFFFF, b=1, out_ready=1 -> out_valid next cycle, out=32'h80000000, eq=0, err=0.
REQ-033 NOR a=32'hFFFFFFFF, b=0 -> out=0, eq=1; then SUB a=5, b=5 issued back-to-back -> out=0, eq=1 on the following cycle, in_ready stays 1.
REQ-034 SLL a=1, b=31 -> out=32'h80000000; SRL a=32'h80000000, b=32'h0000003F (shamt=31) -> out=1.
REQ-035 With LC2K_ALU_MUL_EN: MUL a=32'h00010000, b=32'h00010001 -> in_ready low 32 cycles, out_valid on cycle 33, out=32'h00010000; without the macro: same request -> out=0, eq=1, err=1 after 1 cycle.
REQ-036 Result held with out_ready=0 for 5 cycles -> out/eq stable, in_ready=0, new in_valid ignored; out_ready=1 -> transfer, return to IDLE.
REQ-037 Reset asserted at BUSY cycle 10 of a MUL -> out_valid=0, out=0 immediately; after release a fresh ADD 2+3 returns out=5.

Source files
------------

// File: rtl/lc2k_alu_seq.sv
// ============================================================================
//  Module   : lc2k_alu_seq
//  Purpose  : Sequential LC2K-style ALU with valid/ready handshakes on the
//             request and result sides. ADD/NOR/SUB/AND/SLL/SRL complete in
//             one cycle. MUL is an optional iterative shift-add multiplier
//             that needs DATA_LEN cycles.
//  Config   : Define LC2K_ALU_MUL_EN to build the multiplier and the BUSY
//             state. Without it, op 110 is reported as illegal.
//  Ports    : clock      - rising-edge clock
//             reset      - asynchronous active-high reset
//             in_valid   - request present        in_ready  - request accepted
//             op, a, b   - operation code and operands
//             out_valid  - result held            out_ready - result taken
//             out        - result                 eq        - result == 0
//             err        - illegal op flagged with this result
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc2k_alu_seq #(
    parameter int DATA_LEN  = 32,
    parameter int SHAMT_LEN = $clog2(DATA_LEN)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out,
    output logic                eq,
    output logic                err
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_NOR = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_AND = 3'b011;
    localparam logic [2:0] c_OP_SLL = 3'b100;
    localparam logic [2:0] c_OP_SRL = 3'b101;
`ifdef LC2K_ALU_MUL_EN
    localparam logic [2:0]           c_OP_MUL   = 3'b110;
    localparam logic [SHAMT_LEN-1:0] c_CNT_LAST = SHAMT_LEN'(DATA_LEN - 1);
    localparam logic [SHAMT_LEN-1:0] c_CNT_ONE  = SHAMT_LEN'(1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                w_accept;
    logic [DATA_LEN-1:0] w_alu_res;
    logic                w_alu_err;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);

    // Single-cycle datapath. Anything not listed (reserved op, and MUL when
    // the multiplier is not built) yields a zero result with err set.
    always_comb begin
        w_alu_res = '0;
        w_alu_err = 1'b0;
        case (op)
            c_OP_ADD: w_alu_res = a + b;
            c_OP_NOR: w_alu_res = ~(a | b);
            c_OP_SUB: w_alu_res = a - b;
            c_OP_AND: w_alu_res = a & b;
            c_OP_SLL: w_alu_res = a << b[SHAMT_LEN-1:0];
            c_OP_SRL: w_alu_res = a >> b[SHAMT_LEN-1:0];
            default: begin
                w_alu_res = '0;
                w_alu_err = 1'b1;
            end
        endcase
    end

`ifdef LC2K_ALU_MUL_EN
    // Shift-add multiplier state: multiplicand shifts left and multiplier
    // shifts right each step, so bit 0 of r_mp always selects the addend.
    logic [DATA_LEN-1:0]  r_mc;
    logic [DATA_LEN-1:0]  r_mp;
    logic [DATA_LEN-1:0]  r_acc;
    logic [SHAMT_LEN-1:0] r_cnt;
    logic [DATA_LEN-1:0]  w_acc_next;

    assign w_acc_next = r_mp[0] ? (r_acc + r_mc) : r_acc;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            out     <= '0;
            eq      <= 1'b0;
            err     <= 1'b0;
`ifdef LC2K_ALU_MUL_EN
            r_mc    <= '0;
            r_mp    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
`ifdef LC2K_ALU_MUL_EN
                        if (op == c_OP_MUL) begin
                            // out/eq/err keep their old values until the
                            // final product is known.
                            r_state <= S_BUSY;
                            r_mc    <= a;
                            r_mp    <= b;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end else
`endif
                        begin
                            r_state <= S_DONE;
                            out     <= w_alu_res;
                            eq      <= (w_alu_res == '0);
                            err     <= w_alu_err;
                        end
                    end else if (r_state == S_DONE && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
`ifdef LC2K_ALU_MUL_EN
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    r_mc  <= r_mc << 1;
                    r_mp  <= r_mp >> 1;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    // The last step publishes the finished product directly.
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_DONE;
                        out     <= w_acc_next;
                        eq      <= (w_acc_next == '0);
                        err     <= 1'b0;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lc2k_alu_seq.sv
`default_nettype none

module tb_lc2k_alu_seq;

    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout;
    logic          eq;
    logic          err;

    int checks;
    int failures;

    lc2k_alu_seq #(.DATA_LEN(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (dout),
        .eq       (eq),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef LC2K_ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    // Reference model: returns {err, result}.
    function automatic logic [DW:0] ref_alu(input logic [2:0] o, input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        int sh;
        sh = int'(y % DW);
        p  = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        case (o)
            3'd0: return {1'b0, DW'(x + y)};
            3'd1: return {1'b0, ~(x | y)};
            3'd2: return {1'b0, DW'(x - y)};
            3'd3: return {1'b0, x & y};
            3'd4: return {1'b0, DW'(x << sh)};
            3'd5: return {1'b0, DW'(x >> sh)};
            3'd6: return MUL_ON ? {1'b0, p[DW-1:0]} : {1'b1, {DW{1'b0}}};
            default: return {1'b1, {DW{1'b0}}};
        endcase
    endfunction

    // Present one request for one edge; outputs are then sampled 1 ns later.
    task automatic do_op(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic rdy);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = rdy;
        @(posedge clock); #1;
        in_valid  = 1'b0;
    endtask

    task automatic step;
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || dout !== '0 || eq !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b out=%h eq=%b err=%b exp v=0 out=0 eq=0 err=0",
                     out_valid, dout, eq, err);
        end
        reset = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_directed;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_ready got=%b exp=1", in_ready);
        end
        do_op(3'd0, 32'h7FFF_FFFF, 32'h1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || dout !== 32'h8000_0000 || eq !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL add_ovf got v=%b out=%h eq=%b err=%b exp v=1 out=80000000 eq=0 err=0",
                     out_valid, dout, eq, err);
        end
        step();
        // NOR then SUB back to back
        do_op(3'd1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || dout !== '0 || eq !== 1'b1) begin
            failures++;
            $display("FAIL nor_zero got v=%b out=%h eq=%b exp v=1 out=0 eq=1", out_valid, dout, eq);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready got=%b exp=1", in_ready);
        end
        do_op(3'd2, 32'd5, 32'd5, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || dout !== '0 || eq !== 1'b1 || err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sub_b2b got v=%b out=%h eq=%b err=%b rdy=%b exp v=1 out=0 eq=1 err=0 rdy=1",
                     out_valid, dout, eq, err, in_ready);
        end
        do_op(3'd4, 32'd1, 32'd31, 1'b1);
        checks++;
        if (dout !== 32'h8000_0000 || eq !== 1'b0) begin
            failures++;
            $display("FAIL sll31 got=%h exp=80000000", dout);
        end
        do_op(3'd5, 32'h8000_0000, 32'h0000_003F, 1'b1);
        checks++;
        if (dout !== 32'h1 || eq !== 1'b0) begin
            failures++;
            $display("FAIL srl31 got=%h exp=00000001", dout);
        end
        do_op(3'd7, 32'h1234, 32'h5678, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || dout !== '0 || eq !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL reserved got v=%b out=%h eq=%b err=%b exp v=1 out=0 eq=1 err=1",
                     out_valid, dout, eq, err);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL return_idle got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_mul;
        int lowbad;
        lowbad = 0;
        do_op(3'd6, 32'h0001_0000, 32'h0001_0001, 1'b1);
`ifdef LC2K_ALU_MUL_EN
        // Cycles 1..32 after accept: busy, requests ignored.
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) lowbad++;
            in_valid = 1'b1;
            op       = 3'd0;
            a        = 32'hDEAD;
            b        = 32'hBEEF;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (lowbad != 0) begin
            failures++;
            $display("FAIL mul_busy got bad_cycles=%0d exp=0", lowbad);
        end
        checks++;
        if (out_valid !== 1'b1 || dout !== 32'h0001_0000 || eq !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL mul_result got v=%b out=%h eq=%b err=%b exp v=1 out=00010000 eq=0 err=0",
                     out_valid, dout, eq, err);
        end
`else
        checks++;
        if (out_valid !== 1'b1 || dout !== '0 || eq !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL mul_disabled got v=%b out=%h eq=%b err=%b exp v=1 out=0 eq=1 err=1",
                     out_valid, dout, eq, err);
        end
`endif
        step();
    endtask

    task automatic test_hold;
        logic [DW-1:0] held;
        int bad;
        bad = 0;
        do_op(3'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
        held = 32'h00F0_1234;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || dout !== held || eq !== 1'b0 || in_ready !== 1'b0) bad++;
            in_valid = 1'b1;
            op       = 3'd0;
            a        = 32'h1;
            b        = 32'h1;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable got bad_cycles=%0d exp=0", bad);
        end
        checks++;
        if (dout !== held || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_value got=%h exp=%h", dout, held);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midflight;
`ifdef LC2K_ALU_MUL_EN
        do_op(3'd6, 32'h0000_0003, 32'h0000_0007, 1'b1);
        for (int i = 1; i < 10; i++) step();
`else
        do_op(3'd0, 32'h0000_0003, 32'h0000_0007, 1'b0);
        step();
`endif
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== '0 || eq !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got v=%b out=%h eq=%b err=%b exp v=0 out=0 eq=0 err=0",
                     out_valid, dout, eq, err);
        end
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
        do_op(3'd0, 32'd2, 32'd3, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || dout !== 32'd5) begin
            failures++;
            $display("FAIL post_reset_add got v=%b out=%h exp v=1 out=00000005", out_valid, dout);
        end
        step();
    endtask

    task automatic test_random;
        logic [2:0]    o;
        logic [DW-1:0] x, y;
        logic [DW:0]   exp_v;
        int            wait_cnt;
        int            stall;
        for (int n = 0; n < 60; n++) begin
            o = 3'($urandom_range(0, 7));
            x = DW'($urandom);
            y = DW'($urandom);
            if (n % 7 == 0) y = x;
            exp_v = ref_alu(o, x, y);
            do_op(o, x, y, 1'b0);
            wait_cnt = 0;
            while (out_valid !== 1'b1 && wait_cnt < 2 * DW) begin
                step();
                wait_cnt++;
            end
            checks++;
            if (out_valid !== 1'b1 || dout !== exp_v[DW-1:0] || err !== exp_v[DW]
                || eq !== (exp_v[DW-1:0] == '0)) begin
                failures++;
                $display("FAIL rand_op%0d a=%h b=%h got v=%b out=%h err=%b eq=%b exp out=%h err=%b",
                         o, x, y, out_valid, dout, err, eq, exp_v[DW-1:0], exp_v[DW]);
            end
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) step();
            checks++;
            if (out_valid !== 1'b1 || dout !== exp_v[DW-1:0]) begin
                failures++;
                $display("FAIL rand_stall got v=%b out=%h exp v=1 out=%h", out_valid, dout,
                         exp_v[DW-1:0]);
            end
            out_ready = 1'b1;
            step();
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        #1;
        test_reset();
        test_directed();
        test_mul();
        test_hold();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
